ysyx_22050550_fetch_ctrl: RTL and testbench
===========================================

# ysyx_22050550_fetch_ctrl

Instruction-fetch sequencer between the PC register and the instruction bus. It latches the current fetch PC, issues a single-beat read on an AXI-style AR/R channel, and holds the selected 32-bit instruction for decode. On decode acceptance it pulses the PC register's advance enable. Control-flow redirects from decode flush the in-flight fetch: a request already issued is completed on the bus and its response discarded.

## Interface
- XLEN, 64, PC / datapath width
- ADDR_W, 32, bus address width; `ar_addr = addr_q[ADDR_W-1:0]`
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- pc  in  XLEN  fetch PC from PC register (`npc`, already reflects a same-cycle redirect)
- redirect  in  1  decode control-flow change accepted this cycle (jump && decode valid)
- pc_advance  out  1  PC register advance enable (PC <= PC+4 at next edge)
- ar_valid  out  1  read address valid
- ar_ready  in  1  read address accepted
- ar_addr  out  ADDR_W  read address
- r_valid  in  1  read data valid
- r_ready  out  1  read data accept
- r_data  in  64  read data beat
- r_resp  in  2  response code; nonzero = error
- inst_valid  out  1  instruction presented to decode
- inst_ready  in  1  decode accepts instruction
- inst  out  32  instruction word
- inst_pc  out  XLEN  PC of `inst`
- inst_fault  out  1  fetch fault: bus error or misaligned PC

## Operation
- States: IDLE, LATCH, ADDR, DATA, OUT. Registers: `state`, `addr_q` (XLEN), `kill`, `inst_q`, `fault_q`.
- IDLE: entered on reset; goes to LATCH next cycle.
- LATCH: `addr_q <= pc`.
  - If `redirect`: stay in LATCH and re-latch next cycle.
  - Else if `pc[1:0] != 0`: go to OUT with `fault_q=1`, `inst_q=0`, no bus request.
  - Else: go to ADDR.
- ADDR: `ar_valid=1`. `ar_addr` is held stable until `ar_ready`. On `ar_ready`, go to DATA. A `redirect` here sets `kill`; the address handshake still completes.
- DATA: `r_ready=1`. A `redirect` sets `kill`.
  - On `r_valid` with `kill` (or `redirect` in the same cycle): discard the beat, clear `kill`, go to LATCH.
  - On `r_valid` otherwise: `inst_q = addr_q[2] ? r_data[63:32] : r_data[31:0]`; `fault_q = |r_resp`, with `inst_q=0` when faulted. Go to OUT.
- OUT: `inst_valid=1`, `inst=inst_q`, `inst_pc=addr_q`, `inst_fault=fault_q`.
  - `inst_valid && inst_ready && !redirect`: `pc_advance=1` this cycle, go to LATCH.
  - `redirect`, with or without handshake: the handshake counts as delivered, `pc_advance=0` (redirect owns the PC write), go to LATCH.
  - Otherwise hold with all outputs stable.
- `pc_advance` is asserted only in OUT as above; never in any other state.
- Faulted instructions are delivered like normal ones. Decode raises the trap; the controller does not stall.

## Timing
- Reset values: `ar_valid=0`, `ar_addr=0`, `r_ready=0`, `inst_valid=0`, `inst=0`, `inst_pc=0`, `inst_fault=0`, `pc_advance=0`, `kill=0`, state=IDLE.
- Reset mid-operation returns to IDLE immediately. A bus response outstanding at reset is not waited for; the bus resets together with the core.
- Minimum fetch cost, with zero-wait `ar_ready`/`r_valid` and `inst_ready=1`: 4 cycles per instruction (LATCH, ADDR, DATA, OUT).
- First `ar_valid` appears 2 cycles after reset deassertion (IDLE, then LATCH).
- `ar_addr` is driven from `addr_q` and never changes while `ar_valid=1`.
- `inst*` outputs are registered. No combinational path runs from `inst_ready` to `inst_valid`; `pc_advance` is combinational from `inst_ready` and `redirect`.
- `pc` is sampled only in LATCH, after any PC write from the previous cycle has settled.
- At most one read is outstanding.

## Test plan
- Reset release, `pc=0x80000000`, all handshakes always ready: `ar_addr=0x80000000` at cycle 2, `inst_valid` at cycle 4, `pc_advance` pulses once, next `ar_addr=0x80000004`.
- `pc=0x80000004`, `r_data=0x00100093_00000013`: `inst=0x00100093`, `inst_pc=0x80000004`. With `pc=0x80000000` and the same `r_data`: `inst=0x00000013`.
- `ar_ready` held low for 5 cycles, then `redirect` to `0x80000100` during DATA: response discarded, no `inst_valid`, next `ar_addr=0x80000100`.
- `inst_ready=0` for 3 cycles in OUT: `inst`/`inst_pc` stable, `pc_advance=0`. Then `inst_ready=1` together with `redirect`: `pc_advance=0`, next fetch from the redirected `pc`.
- `r_resp=2'b10`: `inst_fault=1`, `inst=0`. `pc=0x80000002`: `inst_fault=1`, no `ar_valid` issued.
- Reset asserted in DATA: all outputs 0 the next cycle; fetch restarts normally after release.

Source files
------------

// File: rtl/ysyx_22050550_fetch_ctrl.sv
// Instruction-fetch sequencer: latches the fetch PC, issues one AR/R read at a time,
// and holds the selected 32-bit word (or a fault) until decode takes it.
module ysyx_22050550_fetch_ctrl #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [XLEN-1:0]   pc,
    input  logic              redirect,
    output logic              pc_advance,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [63:0]       r_data,
    input  logic [1:0]        r_resp,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [XLEN-1:0]   inst_pc,
    output logic              inst_fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        ADDR  = 3'd2,
        DATA  = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [XLEN-1:0]   addr_q_reg, addr_q_next;
    logic              kill_reg, kill_next;
    logic [31:0]       inst_q_reg, inst_q_next;
    logic              fault_q_reg, fault_q_next;

    logic [31:0]       lane [2];
    logic [31:0]       beat_word;
    logic              beat_fault;

    // Split the 64-bit beat into its two instruction lanes; addr bit 2 picks one.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign lane[gi] = r_data[gi*32 +: 32];
    end

    assign beat_word  = lane[addr_q_reg[2]];
    assign beat_fault = |r_resp;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            addr_q_reg  <= '0;
            kill_reg    <= 1'b0;
            inst_q_reg  <= '0;
            fault_q_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_q_reg  <= addr_q_next;
            kill_reg    <= kill_next;
            inst_q_reg  <= inst_q_next;
            fault_q_reg <= fault_q_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_q_next  = addr_q_reg;
        kill_next    = kill_reg;
        inst_q_next  = inst_q_reg;
        fault_q_next = fault_q_reg;

        case (state_reg)
            IDLE: begin
                state_next = LATCH;
            end

            LATCH: begin
                addr_q_next = pc;
                if (redirect) begin
                    state_next = LATCH;
                end else if (pc[1:0] != 2'b00) begin
                    // Misaligned PC is reported as a faulted instruction without touching the bus.
                    fault_q_next = 1'b1;
                    inst_q_next  = '0;
                    state_next   = OUT;
                end else begin
                    state_next = ADDR;
                end
            end

            ADDR: begin
                if (redirect) begin
                    kill_next = 1'b1;
                end
                if (ar_ready) begin
                    state_next = DATA;
                end
            end

            DATA: begin
                if (r_valid) begin
                    if (kill_reg || redirect) begin
                        // Stale response from a flushed fetch: drop it and refetch.
                        kill_next  = 1'b0;
                        state_next = LATCH;
                    end else begin
                        fault_q_next = beat_fault;
                        inst_q_next  = beat_fault ? 32'd0 : beat_word;
                        state_next   = OUT;
                    end
                end else if (redirect) begin
                    kill_next = 1'b1;
                end
            end

            OUT: begin
                if (inst_ready || redirect) begin
                    state_next = LATCH;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ar_valid   = (state_reg == ADDR);
    assign r_ready    = (state_reg == DATA);
    assign inst_valid = (state_reg == OUT);
    // A redirect owns the PC write, so it suppresses the advance even on a handshake.
    assign pc_advance = (state_reg == OUT) && inst_ready && !redirect;

    assign ar_addr    = addr_q_reg[ADDR_W-1:0];
    assign inst       = inst_q_reg;
    assign inst_pc    = addr_q_reg;
    assign inst_fault = fault_q_reg;

endmodule

// File: tb/tb_ysyx_22050550_fetch_ctrl.sv
// Bench for the fetch sequencer: directed scenarios then random bus/decode behaviour,
// checked against a transaction-level model of fetch timing and instruction selection.
module tb_ysyx_22050550_fetch_ctrl;

    localparam int XLEN   = 64;
    localparam int ADDR_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [XLEN-1:0]   pc;
    logic              redirect;
    logic              pc_advance;
    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic              r_valid;
    logic              r_ready;
    logic [63:0]       r_data;
    logic [1:0]        r_resp;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [XLEN-1:0]   inst_pc;
    logic              inst_fault;

    ysyx_22050550_fetch_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .pc         (pc),
        .redirect   (redirect),
        .pc_advance (pc_advance),
        .ar_valid   (ar_valid),
        .ar_ready   (ar_ready),
        .ar_addr    (ar_addr),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_data     (r_data),
        .r_resp     (r_resp),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_fault (inst_fault)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc;

    // Transaction-level model: which bus/decode phase is expected this cycle.
    bit          in_ar, in_r, in_out, kill_m;
    int          due;
    logic [63:0] pc_m, fetch_pc, rd_target;
    logic [31:0] exp_inst;
    logic        exp_fault;

    // Stimulus knobs (percent chances) and forced redirect.
    int          ar_pct, r_pct, ir_pct, rd_pct, err_pct, mis_pct;
    bit          force_rd, fix_data;
    logic [63:0] data_const, force_target;

    // Observations of DUT activity used by directed checks.
    int          adv_seen = 0, iv_seen = 0, ar_seen = 0;
    logic [31:0] dq [$];
    logic [63:0] last_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit phase_is(input int ph);
        case (ph)
            1:       return in_ar;
            2:       return in_r;
            default: return in_out;
        endcase
    endfunction

    task automatic model_reset();
        in_ar  = 0;
        in_r   = 0;
        in_out = 0;
        kill_m = 0;
        cyc    = 0;
        due    = 2;
    endtask

    task automatic step();
        bit exp_adv;
        bit live;
        live       = in_ar || in_r || in_out;
        ar_ready   = (int'($urandom_range(99)) < ar_pct);
        r_valid    = in_r && (int'($urandom_range(99)) < r_pct);
        r_data     = fix_data ? data_const : {$urandom(), $urandom()};
        r_resp     = (int'($urandom_range(99)) < err_pct) ? 2'b10 : 2'b00;
        inst_ready = (int'($urandom_range(99)) < ir_pct);
        redirect   = live && (force_rd || (int'($urandom_range(99)) < rd_pct));
        if (force_rd)
            rd_target = force_target;
        else
            rd_target = 64'h8000_0000 + 64'($urandom_range(1023)) * 64'd4
                      + ((int'($urandom_range(99)) < mis_pct) ? 64'd2 : 64'd0);
        pc = pc_m;

        @(negedge clock);
        chk("ar_valid", ar_valid, in_ar);
        chk("r_ready", r_ready, in_r);
        chk("inst_valid", inst_valid, in_out);
        if (in_ar) chk("ar_addr", ar_addr, fetch_pc[ADDR_W-1:0]);
        if (in_out) begin
            chk("inst", inst, exp_inst);
            chk("inst_pc", inst_pc, fetch_pc);
            chk("inst_fault", inst_fault, exp_fault);
        end
        exp_adv = in_out && inst_ready && !redirect;
        chk("pc_advance", pc_advance, exp_adv);

        if (pc_advance) adv_seen++;
        if (inst_valid) iv_seen++;
        if (ar_valid)   ar_seen++;
        if (inst_valid && (inst_ready || redirect)) begin
            dq.push_back(inst);
            last_pc = inst_pc;
        end

        if (in_ar) begin
            if (redirect) kill_m = 1;
            if (ar_ready) begin
                in_ar = 0;
                in_r  = 1;
            end
        end else if (in_r) begin
            if (r_valid) begin
                in_r = 0;
                if (kill_m || redirect) begin
                    kill_m = 0;
                    due    = cyc + 2;
                end else begin
                    exp_fault = |r_resp;
                    exp_inst  = exp_fault ? 32'd0 : (fetch_pc[2] ? r_data[63:32] : r_data[31:0]);
                    in_out    = 1;
                end
            end else if (redirect) begin
                kill_m = 1;
            end
        end else if (in_out) begin
            if (inst_ready || redirect) begin
                in_out = 0;
                due    = cyc + 2;
            end
        end else if (cyc + 1 == due) begin
            fetch_pc = pc_m;
            if (pc_m[1:0] != 2'b00) begin
                in_out    = 1;
                exp_fault = 1;
                exp_inst  = 32'd0;
            end else begin
                in_ar = 1;
            end
        end

        if (redirect)     pc_m = rd_target;
        else if (exp_adv) pc_m = pc_m + 64'd4;

        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int ph, input int budget, input string tag);
        int n;
        n = 0;
        while (!phase_is(ph) && n < budget) begin
            step();
            n++;
        end
        assert (phase_is(ph)) else begin
            errors++;
            $error("FAIL %s phase %0d not reached within %0d cycles", tag, ph, budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int adv_snap, iv_snap, ar_snap;

        reset      = 1'b1;
        redirect   = 1'b0;
        ar_ready   = 1'b0;
        r_valid    = 1'b0;
        inst_ready = 1'b0;
        r_data     = '0;
        r_resp     = 2'b00;
        pc_m       = 64'h8000_0000;
        pc         = pc_m;
        force_rd   = 0;
        force_target = '0;
        cyc        = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ar_valid", ar_valid, 0);
        chk("rst_ar_addr", ar_addr, 0);
        chk("rst_r_ready", r_ready, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_inst_fault", inst_fault, 0);
        chk("rst_pc_advance", pc_advance, 0);
        reset = 1'b0;
        model_reset();

        // Zero-wait fetch with a fixed two-instruction beat.
        ar_pct = 100; r_pct = 100; ir_pct = 100; rd_pct = 0; err_pct = 0; mis_pct = 0;
        fix_data = 1; data_const = 64'h00100093_00000013;
        repeat (2) step();
        chk("t1_ar_valid_c2", ar_valid, 1);
        chk("t1_ar_addr_c2", ar_addr, 32'h8000_0000);
        repeat (10) step();
        chk("t1_adv_count", adv_seen, 2);
        chk("t2_inst_lo", dq[0], 32'h0000_0013);
        chk("t2_inst_hi", dq[1], 32'h0010_0093);
        chk("t2_inst_pc", last_pc, 64'h8000_0004);

        // Address stall, then redirect in DATA with a same-cycle response.
        fix_data = 0; ar_pct = 0;
        run_to(1, 20, "t3_reach_addr");
        repeat (5) step();
        ar_pct = 100; r_pct = 0;
        run_to(2, 5, "t3_reach_data");
        iv_snap = iv_seen;
        force_rd = 1; force_target = 64'h8000_0100; r_pct = 100;
        step();
        force_rd = 0;
        run_to(1, 10, "t3_refetch");
        chk("t3_no_inst_valid", iv_seen - iv_snap, 0);
        chk("t3_ar_addr", ar_addr, 32'h8000_0100);

        // Decode stall for 3 cycles, then accept together with a redirect.
        ir_pct = 0;
        run_to(3, 20, "t4_reach_out");
        repeat (3) step();
        adv_snap = adv_seen;
        ir_pct = 100; force_rd = 1; force_target = 64'h8000_0200;
        step();
        force_rd = 0;
        chk("t4_no_advance", adv_seen - adv_snap, 0);
        run_to(1, 10, "t4_refetch");
        chk("t4_ar_addr", ar_addr, 32'h8000_0200);

        // Bus error, then a misaligned redirect target.
        err_pct = 100;
        run_to(3, 20, "t5_reach_out");
        chk("t5_err_fault", inst_fault, 1);
        chk("t5_err_inst", inst, 0);
        err_pct = 0; force_rd = 1; force_target = 64'h8000_0002;
        step();
        force_rd = 0;
        ar_snap = ar_seen;
        run_to(3, 10, "t5_reach_mis");
        chk("t5_mis_fault", inst_fault, 1);
        chk("t5_mis_inst_pc", inst_pc, 64'h8000_0002);
        chk("t5_mis_no_ar", ar_seen - ar_snap, 0);
        force_rd = 1; force_target = 64'h8000_0300;
        step();
        force_rd = 0;

        // Reset while a response is outstanding.
        r_pct = 0;
        run_to(2, 20, "t6_reach_data");
        reset = 1'b1; redirect = 1'b0;
        @(posedge clock);
        #1;
        chk("t6_ar_valid", ar_valid, 0);
        chk("t6_ar_addr", ar_addr, 0);
        chk("t6_r_ready", r_ready, 0);
        chk("t6_inst_valid", inst_valid, 0);
        chk("t6_inst", inst, 0);
        chk("t6_inst_pc", inst_pc, 0);
        chk("t6_inst_fault", inst_fault, 0);
        chk("t6_pc_advance", pc_advance, 0);
        reset = 1'b0;
        model_reset();
        r_pct = 100;
        adv_snap = adv_seen;
        repeat (12) step();
        chk("t6_restart_adv", adv_seen - adv_snap, 2);

        // Random bus latency, decode stalls, redirects, errors and misalignment.
        ar_pct = 70; r_pct = 60; ir_pct = 60; rd_pct = 8; err_pct = 10; mis_pct = 15;
        repeat (4000) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
